wb_grf: RTL and testbench
=========================

Name: wb_grf

Overview:
- Write-back end of the 5-stage pipeline; consumes the MEM/WB register outputs (Instr, pc, ALUout, DMout).
- Decodes the retiring instruction and selects/extends the write-back data.
- Writes the 32x32 general register file and serves the two D-stage read ports, with same-cycle write-through bypass.
- Counts retired instructions and exposes a write-back trace.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (wraps modulo 2^CNT_W).
- BYPASS_EN, 1, 1 = read ports return data being written this cycle; 0 = read ports return the array contents only.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; clears all state immediately when low.
- Instr  input  32  retiring instruction; 32'd0 is a bubble.
- pc  input  32  PC of retiring instruction.
- ALUout  input  32  ALU result; bits [1:0] are the byte offset for loads.
- DMout  input  32  raw aligned data-memory word.
- rs_addr  input  5  read port A address.
- rt_addr  input  5  read port B address.
- rs_data  output  32  read port A data (combinational).
- rt_data  output  32  read port B data (combinational).
- wb_en  output  1  a register write commits at the next posedge.
- wb_addr  output  5  destination register.
- wb_data  output  32  value being written.
- wb_pc  output  32  pc of the writing instruction (trace).
- retire_cnt  output  CNT_W  number of non-bubble instructions retired.

Behaviour:
- Reset (reset low, asynchronous):
  - all 32 registers clear to 0;
  - retire_cnt clears to 0;
  - wb_en is forced to 0 while reset is low.
  - Deassertion takes effect at the next posedge.
- Decode (combinational, from Instr; opcode/funct constants come from the shared macro include):
  - R-type add/sub/and/or/slt/sltu: dest = rd; data = ALUout.
  - ori/andi/addi/addiu/lui/slti: dest = rt; data = ALUout.
  - lw: dest = rt; data = DMout.
  - lb/lbu: byte select by ALUout[1:0] (00 = bits 7:0 ... 11 = bits 31:24); sign- or zero-extend.
  - lh/lhu: half select by ALUout[1] (0 = 15:0, 1 = 31:16); ALUout[0] is ignored; sign- or zero-extend.
  - jal: dest = 31; data = pc + 8.
  - jalr: dest = rd; data = pc + 8.
  - All other opcodes (sw/sb/sh/beq/bne/j/jr/bubble/unknown): no write.
- wb_en = decoded write AND dest != 0 AND reset high. Writes to $0 are suppressed; $0 always reads 0.
- Commit: at posedge with wb_en = 1, reg[wb_addr] <= wb_data. Write latency is 1 edge.
- Read ports:
  - addr 0 returns 0.
  - Else, if BYPASS_EN and wb_en and addr == wb_addr, return wb_data (same-cycle write-through).
  - Else return reg[addr].
  - Both ports may hit the same address or the bypass simultaneously.
- retire_cnt:
  - increments by 1 at each posedge where Instr != 0 and reset is high, including non-writing instructions.
  - Wraps from all-ones to 0.
- Reset asserted mid-cycle: the pending write is dropped and no count is taken for that cycle.
- wb_pc = pc passthrough; meaningful only when wb_en = 1.

Decomposition:
- Shared macro include: opcode and funct constants, register number 31 for $ra, bubble encoding 0.
- Sub-module wb_load_ext (combinational): DMout, offset[1:0], and load-type encoding in; extended 32-bit word out.
- The register array, decode, bypass and counter stay in wb_grf.

Test Plan:
- Reset released; Instr = ori $5 with ALUout = 32'h0000_1234 for one edge → reg5 = 32'h0000_1234; rs_addr = 5 reads 32'h0000_1234; retire_cnt = 1.
- lb with DMout = 32'h80FF_7F01 at offsets 0/1/2/3 → wb_data = 32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80. lbu at offset 3 → 32'h0000_0080. lh at ALUout = 2 → 32'hFFFF_80FF.
- jal at pc = 32'h0000_3000 → reg31 = 32'h0000_3008. Same cycle with rt_addr = 31 and BYPASS_EN = 1 → rt_data = 32'h0000_3008 before the edge.
- add with rd = 0 and ALUout = 32'hDEAD_BEEF → wb_en = 0; rs_addr = 0 reads 0. sw retires → retire_cnt increments, no register changes. Bubble (Instr = 0) → no count.
- Pre-load retire_cnt to all-ones (CNT_W = 4, 15 retirements) and retire one more → retire_cnt = 0.
- Load reg7 = 32'h1; drive reset low asynchronously between edges with a pending write to reg8 → reg7 = 0 immediately, reg8 is never written, and retire_cnt = 0.

Source files
------------

// File: rtl/wb_grf_pkg.sv
// Shared constants for the write-back stage: opcode/funct encodings, $ra, bubble
// encoding and the load-extension selector.
package wb_grf_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [4:0]  REG_RA       = 5'd31;
    localparam logic [31:0] INSTR_BUBBLE = 32'd0;

    typedef enum logic [2:0] {
        LD_NONE,
        LD_W,
        LD_B,
        LD_BU,
        LD_H,
        LD_HU
    } ld_type_e;

endpackage

// File: rtl/wb_grf_if.sv
// MEM/WB-to-register-file bus: retiring instruction in, D-stage read ports and
// write-back trace out.
interface wb_grf_if #(parameter int CNT_W = 32);
    logic [31:0]      Instr;
    logic [31:0]      pc;
    logic [31:0]      ALUout;
    logic [31:0]      DMout;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic [31:0]      rs_data;
    logic [31:0]      rt_data;
    logic             wb_en;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;
    logic [31:0]      wb_pc;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output Instr, pc, ALUout, DMout, rs_addr, rt_addr,
        input  rs_data, rt_data, wb_en, wb_addr, wb_data, wb_pc, retire_cnt
    );

    modport slave (
        input  Instr, pc, ALUout, DMout, rs_addr, rt_addr,
        output rs_data, rt_data, wb_en, wb_addr, wb_data, wb_pc, retire_cnt
    );
endinterface

// File: rtl/wb_load_ext.sv
// Load data alignment: picks the addressed byte/half of the memory word and
// sign- or zero-extends it to 32 bits.
module wb_load_ext
    import wb_grf_pkg::*;
(
    input  logic [31:0] dm,
    input  logic [1:0]  offset,
    input  ld_type_e    ld_type,
    output logic [31:0] data
);

    logic signed [7:0]  byte_v;
    logic signed [15:0] half_v;

    always_comb begin
        case (offset)
            2'b00:   byte_v = dm[7:0];
            2'b01:   byte_v = dm[15:8];
            2'b10:   byte_v = dm[23:16];
            default: byte_v = dm[31:24];
        endcase
        // Halfword loads ignore offset[0]; a misaligned lh reads the enclosing half.
        half_v = offset[1] ? dm[31:16] : dm[15:0];

        case (ld_type)
            LD_B:    data = 32'(byte_v);
            LD_BU:   data = {24'd0, byte_v};
            LD_H:    data = 32'(half_v);
            LD_HU:   data = {16'd0, half_v};
            default: data = dm;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// Write-back stage: decodes the retiring instruction, writes the 32x32 register
// file, serves two bypassed read ports and counts retired instructions.
module wb_grf
    import wb_grf_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    wb_grf_if.slave  bus
);

    logic [31:0]      regs [32];
    logic [CNT_W-1:0] cnt;

    logic [5:0]  op, funct;
    logic [4:0]  rt, rd;
    logic        wr, link;
    logic [4:0]  dest;
    ld_type_e    ld_type;
    logic [31:0] ld_data;
    logic        wen;
    logic [31:0] wdata;

    assign op    = bus.Instr[31:26];
    assign rt    = bus.Instr[20:16];
    assign rd    = bus.Instr[15:11];
    assign funct = bus.Instr[5:0];

    always_comb begin
        wr      = 1'b0;
        link    = 1'b0;
        dest    = 5'd0;
        ld_type = LD_NONE;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU: begin
                        wr   = 1'b1;
                        dest = rd;
                    end
                    FN_JALR: begin
                        wr   = 1'b1;
                        link = 1'b1;
                        dest = rd;
                    end
                    FN_JR:   ;
                    default: ;
                endcase
            end
            OP_ORI, OP_ANDI, OP_ADDI, OP_ADDIU, OP_LUI, OP_SLTI: begin
                wr   = 1'b1;
                dest = rt;
            end
            OP_LW:  begin wr = 1'b1; dest = rt; ld_type = LD_W;  end
            OP_LB:  begin wr = 1'b1; dest = rt; ld_type = LD_B;  end
            OP_LBU: begin wr = 1'b1; dest = rt; ld_type = LD_BU; end
            OP_LH:  begin wr = 1'b1; dest = rt; ld_type = LD_H;  end
            OP_LHU: begin wr = 1'b1; dest = rt; ld_type = LD_HU; end
            OP_JAL: begin
                wr   = 1'b1;
                link = 1'b1;
                dest = REG_RA;
            end
            OP_SW, OP_SB, OP_SH, OP_BEQ, OP_BNE, OP_J: ;
            default: ;
        endcase
    end

    wb_load_ext u_load_ext (
        .dm      (bus.DMout),
        .offset  (bus.ALUout[1:0]),
        .ld_type (ld_type),
        .data    (ld_data)
    );

    // Gating with reset makes a write pending at reset assertion vanish at once.
    assign wen   = wr && (dest != 5'd0) && reset;
    assign wdata = link ? (bus.pc + 32'd8)
                 : (ld_type != LD_NONE) ? ld_data
                 : bus.ALUout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (wen) begin
            regs[dest] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (bus.Instr != INSTR_BUBBLE) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    function automatic logic [31:0] rd_port(input logic [4:0]  a,
                                            input logic [31:0] arr_val,
                                            input logic        w_en,
                                            input logic [4:0]  w_addr,
                                            input logic [31:0] w_data);
        if (a == 5'd0)
            return 32'd0;
        else if (BYPASS_EN && w_en && (a == w_addr))
            return w_data;
        else
            return arr_val;
    endfunction

    assign bus.rs_data    = rd_port(bus.rs_addr, regs[bus.rs_addr], wen, dest, wdata);
    assign bus.rt_data    = rd_port(bus.rt_addr, regs[bus.rt_addr], wen, dest, wdata);
    assign bus.wb_en      = wen;
    assign bus.wb_addr    = dest;
    assign bus.wb_data    = wdata;
    assign bus.wb_pc      = bus.pc;
    assign bus.retire_cnt = cnt;

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: decode/extension, bypass, $0 suppression,
// counter wrap and asynchronous reset with a pending write.
module tb_wb_grf;
    import wb_grf_pkg::*;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_grf_if #(.CNT_W(CNT_W)) bus ();

    wb_grf #(.CNT_W(CNT_W), .BYPASS_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rdn, input logic [5:0] fn);
        return {OP_RTYPE, 5'd0, 5'd0, rdn, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rtn);
        return {opc, 5'd0, rtn, 16'h0000};
    endfunction

    // Apply one retiring instruction mid-cycle; it commits at the next posedge.
    task automatic drive(input logic [31:0] instr, input logic [31:0] pcv,
                         input logic [31:0] alu, input logic [31:0] dm);
        @(negedge clk);
        bus.Instr  = instr;
        bus.pc     = pcv;
        bus.ALUout = alu;
        bus.DMout  = dm;
        #1;
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp);
        check(tag, 32'(bus.retire_cnt), 32'(exp));
    endtask

    initial begin
        bus.Instr   = 32'd0;
        bus.pc      = 32'd0;
        bus.ALUout  = 32'd0;
        bus.DMout   = 32'd0;
        bus.rs_addr = 5'd0;
        bus.rt_addr = 5'd0;

        // Held in reset: a writing instruction must not enable a write or count.
        bus.rs_addr = 5'd5;
        drive(itype(OP_ORI, 5'd5), 32'h100, 32'h0000_1234, 32'd0);
        check("rst_wb_en", 32'(bus.wb_en), 32'd0);
        chk_cnt("rst_cnt", 4'd0);
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        check("rst_reg5", bus.rs_data, 32'd0);
        reset = 1'b1;

        drive(itype(OP_ORI, 5'd5), 32'h100, 32'h0000_1234, 32'd0);
        chk_cnt("cnt_after_rel", 4'd0);
        check("ori_wb_en", 32'(bus.wb_en), 32'd1);
        check("ori_wb_addr", 32'(bus.wb_addr), 32'd5);
        check("ori_wb_data", bus.wb_data, 32'h0000_1234);
        check("ori_wb_pc", bus.wb_pc, 32'h100);
        check("ori_bypass", bus.rs_data, 32'h0000_1234);
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        check("bubble_wb_en", 32'(bus.wb_en), 32'd0);
        check("reg5_read", bus.rs_data, 32'h0000_1234);
        chk_cnt("cnt_1", 4'd1);

        // Byte/half extension on one memory word.
        drive(itype(OP_LB, 5'd6), 32'h104, 32'h0000_0200, 32'h80FF_7F01);
        check("lb_off0", bus.wb_data, 32'h0000_0001);
        drive(itype(OP_LB, 5'd6), 32'h108, 32'h0000_0201, 32'h80FF_7F01);
        check("lb_off1", bus.wb_data, 32'h0000_007F);
        drive(itype(OP_LB, 5'd6), 32'h10C, 32'h0000_0202, 32'h80FF_7F01);
        check("lb_off2", bus.wb_data, 32'hFFFF_FFFF);
        drive(itype(OP_LB, 5'd6), 32'h110, 32'h0000_0203, 32'h80FF_7F01);
        check("lb_off3", bus.wb_data, 32'hFFFF_FF80);
        drive(itype(OP_LBU, 5'd6), 32'h114, 32'h0000_0203, 32'h80FF_7F01);
        check("lbu_off3", bus.wb_data, 32'h0000_0080);
        drive(itype(OP_LH, 5'd6), 32'h118, 32'h0000_0002, 32'h80FF_7F01);
        check("lh_off2", bus.wb_data, 32'hFFFF_80FF);
        drive(itype(OP_LHU, 5'd6), 32'h11C, 32'h0000_0003, 32'h80FF_7F01);
        check("lhu_off3", bus.wb_data, 32'h0000_80FF);
        drive(itype(OP_LH, 5'd6), 32'h120, 32'h0000_0000, 32'h80FF_7F01);
        check("lh_off0", bus.wb_data, 32'h0000_7F01);
        drive(itype(OP_LW, 5'd6), 32'h124, 32'h0000_0001, 32'h80FF_7F01);
        check("lw_data", bus.wb_data, 32'h80FF_7F01);
        bus.rs_addr = 5'd6;
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        check("reg6_lw", bus.rs_data, 32'h80FF_7F01);
        chk_cnt("cnt_10", 4'd10);

        // jal: link to $31 with write-through on port B.
        bus.rs_addr = 5'd5;
        bus.rt_addr = 5'd31;
        drive({OP_JAL, 26'h0000C00}, 32'h0000_3000, 32'h0, 32'h0);
        check("jal_wb_addr", 32'(bus.wb_addr), 32'd31);
        check("jal_wb_data", bus.wb_data, 32'h0000_3008);
        check("jal_rt_bypass", bus.rt_data, 32'h0000_3008);
        check("jal_rs_nobyp", bus.rs_data, 32'h0000_1234);

        // Write to $0 suppressed; $0 reads zero.
        bus.rs_addr = 5'd0;
        drive(rtype(5'd0, FN_ADD), 32'h3008, 32'hDEAD_BEEF, 32'h0);
        check("add_r0_wb_en", 32'(bus.wb_en), 32'd0);
        check("r0_read", bus.rs_data, 32'd0);
        check("reg31_read", bus.rt_data, 32'h0000_3008);

        // Store retires without writing.
        bus.rs_addr = 5'd5;
        drive(itype(OP_SW, 5'd5), 32'h300C, 32'h0000_0040, 32'h0);
        check("sw_wb_en", 32'(bus.wb_en), 32'd0);
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        check("sw_reg5_kept", bus.rs_data, 32'h0000_1234);
        chk_cnt("cnt_13", 4'd13);
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        chk_cnt("bubble_nocount", 4'd13);

        // Counter wrap: bring it to 15 with non-writing ops, then one more.
        drive(itype(OP_BEQ, 5'd0), 32'h3010, 32'h0, 32'h0);
        drive(rtype(5'd0, FN_JR), 32'h3014, 32'h0, 32'h0);
        check("jr_wb_en", 32'(bus.wb_en), 32'd0);
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        chk_cnt("cnt_15", 4'd15);
        drive({OP_J, 26'h0000001}, 32'h3018, 32'h0, 32'h0);
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        chk_cnt("cnt_wrap", 4'd0);

        // jalr with both ports on the destination.
        bus.rs_addr = 5'd9;
        bus.rt_addr = 5'd9;
        drive(rtype(5'd9, FN_JALR), 32'h0000_0040, 32'h0, 32'h0);
        check("jalr_wb_addr", 32'(bus.wb_addr), 32'd9);
        check("jalr_rs", bus.rs_data, 32'h0000_0048);
        check("jalr_rt", bus.rt_data, 32'h0000_0048);

        // Asynchronous reset with a write to $8 pending.
        drive(rtype(5'd7, FN_ADD), 32'h50, 32'h0000_0001, 32'h0);
        bus.rs_addr = 5'd7;
        bus.rt_addr = 5'd8;
        drive(itype(OP_ORI, 5'd8), 32'h54, 32'h0000_0088, 32'h0);
        check("reg7_loaded", bus.rs_data, 32'h0000_0001);
        check("r8_pending_en", 32'(bus.wb_en), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reg7", bus.rs_data, 32'd0);
        check("async_wb_en", 32'(bus.wb_en), 32'd0);
        chk_cnt("async_cnt", 4'd0);
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        reset = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 32'd0);
        check("reg8_unwritten", bus.rt_data, 32'd0);
        chk_cnt("cnt_after_rst", 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
